// File: rtl/cordic_hyperbolic_iter_if.sv
// Handshake, operand, result and external atanh-ROM signals of the
// iterative hyperbolic CORDIC engine.
interface cordic_hyperbolic_iter_if #(
  parameter int FIXED_WIDTH = 16,
  parameter int ITERATIONS  = 9
);
  logic                           start;
  logic                           mode;
  logic signed [FIXED_WIDTH-1:0]  x_in;
  logic signed [FIXED_WIDTH-1:0]  y_in;
  logic signed [FIXED_WIDTH-1:0]  z_in;
  logic [$clog2(ITERATIONS)-1:0]  rom_idx;
  logic signed [FIXED_WIDTH-1:0]  rom_angle;
  logic                           busy;
  logic                           done;
  logic signed [FIXED_WIDTH-1:0]  x_out;
  logic signed [FIXED_WIDTH-1:0]  y_out;
  logic signed [FIXED_WIDTH-1:0]  z_out;

  modport master (
    output start, mode, x_in, y_in, z_in, rom_angle,
    input  rom_idx, busy, done, x_out, y_out, z_out
  );

  modport slave (
    input  start, mode, x_in, y_in, z_in, rom_angle,
    output rom_idx, busy, done, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_hyperbolic_iter.sv
// Iterative hyperbolic CORDIC: one micro-rotation per RUN cycle, atanh
// angles fetched combinationally from an external ROM, no gain correction.
module cordic_hyperbolic_iter #(
  parameter int FIXED_WIDTH = 16,
  parameter int ITERATIONS  = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  cordic_hyperbolic_iter_if.slave  bus
);
  localparam int IW   = $clog2(ITERATIONS);
  localparam int LAST = ITERATIONS - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state, state_n;
  logic signed [FIXED_WIDTH-1:0] x, y, z;
  logic signed [FIXED_WIDTH-1:0] x_n, y_n, z_n;
  logic signed [FIXED_WIDTH-1:0] xs, ys;
  logic signed [FIXED_WIDTH-1:0] xo, yo, zo;
  logic [IW-1:0]                 sidx;
  logic                          rep;
  logic                          mode_r;
  logic                          repeat_here;
  logic                          last_step;
  logic                          dpos;

  // Indices 4 and 13 run twice: rep marks that the first pass is done.
  always_comb begin
    repeat_here = ((int'(sidx) == 4) || (int'(sidx) == 13)) && !rep;
    last_step   = (int'(sidx) == LAST) && !repeat_here;
    xs          = x >>> sidx;
    ys          = y >>> sidx;
    dpos        = mode_r ? y[FIXED_WIDTH-1] : !z[FIXED_WIDTH-1];
    if (dpos) begin
      x_n = x + ys;
      y_n = y + xs;
      z_n = z - bus.rom_angle;
    end else begin
      x_n = x - ys;
      y_n = y - xs;
      z_n = z + bus.rom_angle;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last_step) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      z      <= '0;
      xo     <= '0;
      yo     <= '0;
      zo     <= '0;
      sidx   <= '0;
      rep    <= 1'b0;
      mode_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x      <= bus.x_in;
            y      <= bus.y_in;
            z      <= bus.z_in;
            mode_r <= bus.mode;
            sidx   <= IW'(1);
            rep    <= 1'b0;
          end
        end
        RUN: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          if (repeat_here) begin
            rep <= 1'b1;
          end else begin
            rep  <= 1'b0;
            sidx <= sidx + 1'b1;
          end
          if (last_step) begin
            xo <= x_n;
            yo <= y_n;
            zo <= z_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.rom_idx = (state == RUN) ? sidx : '0;
  assign bus.x_out   = xo;
  assign bus.y_out   = yo;
  assign bus.z_out   = zo;
endmodule

// File: tb/tb_cordic_hyperbolic_iter.sv
// Bench for cordic_hyperbolic_iter: provides the atanh ROM and compares
// against a list-driven arithmetic reference of the micro-rotation rules.
module tb_cordic_hyperbolic_iter;
  localparam int FW   = 16;
  localparam int ITER = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic signed [FW-1:0] rom_tab [0:15];

  int snap_busy, snap_done, snap_idx, snap_x, snap_y, snap_z;

  cordic_hyperbolic_iter_if #(.FIXED_WIDTH(FW), .ITERATIONS(ITER)) bus ();

  cordic_hyperbolic_iter #(.FIXED_WIDTH(FW), .ITERATIONS(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_angle = rom_tab[bus.rom_idx];

  function automatic int wrap(input int v);
    logic signed [FW-1:0] t;
    t = v[FW-1:0];
    return int'(t);
  endfunction

  task automatic model(input bit m, input int xi, input int yi, input int zi,
                       output int xo, output int yo, output int zo);
    int q[$];
    int x, y, z, xn, yn, d, s;
    x = xi; y = yi; z = zi;
    for (int i = 1; i < ITER; i++) begin
      q.push_back(i);
      if (i == 4 || i == 13) q.push_back(i);
    end
    foreach (q[k]) begin
      s  = q[k];
      d  = m ? ((y < 0) ? 1 : -1) : ((z >= 0) ? 1 : -1);
      xn = wrap(x + d * (y >>> s));
      yn = wrap(y + d * (x >>> s));
      z  = wrap(z - d * int'(rom_tab[s]));
      x  = xn;
      y  = yn;
    end
    xo = x; yo = y; zo = z;
  endtask

  // Drives one operation and watches a fixed 24-edge window; optional
  // injection of start (new operands) or rst after edge inj_at.
  task automatic run_op(input bit m, input int xi, input int yi, input int zi,
                        input int inj_at, input bit inj_rst,
                        output int done_edge, output int pulses);
    done_edge = -1;
    pulses    = 0;
    bus.mode  = m;
    bus.x_in  = FW'(xi);
    bus.y_in  = FW'(yi);
    bus.z_in  = FW'(zi);
    bus.start = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (n == 1) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        if (done_edge < 0) done_edge = n;
      end
      if (n == inj_at + 1) begin
        rst       = 1'b0;
        bus.start = 1'b0;
        snap_busy = int'(bus.busy);
        snap_done = int'(bus.done);
        snap_idx  = int'(bus.rom_idx);
        snap_x    = int'(bus.x_out);
        snap_y    = int'(bus.y_out);
        snap_z    = int'(bus.z_out);
      end
      if (n == inj_at) begin
        if (inj_rst) rst = 1'b1;
        else begin
          bus.start = 1'b1;
          bus.mode  = ~m;
          bus.x_in  = FW'($urandom);
          bus.y_in  = FW'($urandom);
          bus.z_in  = FW'($urandom);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.x_in  = 16'sd1000;
    bus.y_in  = 16'sd0;
    bus.z_in  = 16'sd0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.rom_idx !== '0) begin
      errors++;
      $display("FAIL reset_rom_idx: got %0d required 0", bus.rom_idx);
    end
    checks++;
    if (bus.x_out !== '0 || bus.y_out !== '0 || bus.z_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0d %0d %0d required 0 0 0", bus.x_out, bus.y_out, bus.z_out);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_rotation(input int zi, input int exp_y, input string tag);
    int de, pc, ex, ey, ez;
    run_op(1'b0, 9892, 0, zi, -5, 1'b0, de, pc);
    model(1'b0, 9892, 0, zi, ex, ey, ez);
    checks++;
    if (de !== 10 || pc !== 1) begin
      errors++;
      $display("FAIL %s_timing: done edge %0d pulses %0d required 10 1", tag, de, pc);
    end
    checks++;
    if (int'(bus.x_out) > 9237 + 24 || int'(bus.x_out) < 9237 - 24 ||
        int'(bus.y_out) > exp_y + 24 || int'(bus.y_out) < exp_y - 24 ||
        int'(bus.z_out) > 24 || int'(bus.z_out) < -24) begin
      errors++;
      $display("FAIL %s_accuracy: got %0d %0d %0d required ~9237 ~%0d ~0", tag,
               bus.x_out, bus.y_out, bus.z_out, exp_y);
    end
    checks++;
    if (int'(bus.x_out) !== ex || int'(bus.y_out) !== ey || int'(bus.z_out) !== ez) begin
      errors++;
      $display("FAIL %s_exact: got %0d %0d %0d required %0d %0d %0d", tag,
               bus.x_out, bus.y_out, bus.z_out, ex, ey, ez);
    end
  endtask

  task automatic test_vectoring();
    int de, pc, ex, ey, ez;
    run_op(1'b1, 8192, 4096, 0, -5, 1'b0, de, pc);
    model(1'b1, 8192, 4096, 0, ex, ey, ez);
    checks++;
    if (de !== 10 || pc !== 1) begin
      errors++;
      $display("FAIL vec_timing: done edge %0d pulses %0d required 10 1", de, pc);
    end
    checks++;
    if (int'(bus.z_out) > 4500 + 16 || int'(bus.z_out) < 4500 - 16 ||
        int'(bus.y_out) > 16 || int'(bus.y_out) < -16) begin
      errors++;
      $display("FAIL vec_accuracy: z=%0d y=%0d required ~4500 ~0", bus.z_out, bus.y_out);
    end
    checks++;
    if (int'(bus.x_out) !== ex || int'(bus.y_out) !== ey || int'(bus.z_out) !== ez) begin
      errors++;
      $display("FAIL vec_exact: got %0d %0d %0d required %0d %0d %0d",
               bus.x_out, bus.y_out, bus.z_out, ex, ey, ez);
    end
  endtask

  task automatic test_rom_trace();
    int seq [9] = '{1, 2, 3, 4, 4, 5, 6, 7, 8};
    int exp_idx, exp_busy, exp_done;
    bus.mode  = 1'b0;
    bus.x_in  = 16'sd9892;
    bus.y_in  = 16'sd0;
    bus.z_in  = 16'sd2000;
    bus.start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 1) bus.start = 1'b0;
      exp_idx  = (n <= 9) ? seq[n-1] : 0;
      exp_busy = (n <= 9) ? 1 : 0;
      exp_done = (n == 10) ? 1 : 0;
      checks++;
      if (int'(bus.rom_idx) !== exp_idx || int'(bus.busy) !== exp_busy ||
          int'(bus.done) !== exp_done) begin
        errors++;
        $display("FAIL rom_trace[%0d]: idx=%0d busy=%0d done=%0d required %0d %0d %0d",
                 n, bus.rom_idx, bus.busy, bus.done, exp_idx, exp_busy, exp_done);
      end
    end
  endtask

  task automatic test_start_during_run();
    int de, pc, ex, ey, ez;
    run_op(1'b0, 7000, -1500, 3000, 3, 1'b0, de, pc);
    model(1'b0, 7000, -1500, 3000, ex, ey, ez);
    checks++;
    if (de !== 10 || pc !== 1) begin
      errors++;
      $display("FAIL start_in_run_timing: done edge %0d pulses %0d required 10 1", de, pc);
    end
    checks++;
    if (int'(bus.x_out) !== ex || int'(bus.y_out) !== ey || int'(bus.z_out) !== ez) begin
      errors++;
      $display("FAIL start_in_run_result: got %0d %0d %0d required %0d %0d %0d",
               bus.x_out, bus.y_out, bus.z_out, ex, ey, ez);
    end
  endtask

  task automatic test_reset_midrun();
    int de, pc, ex, ey, ez;
    run_op(1'b1, 6000, -2000, 100, 5, 1'b1, de, pc);
    checks++;
    if (snap_busy !== 0 || snap_done !== 0 || snap_idx !== 0) begin
      errors++;
      $display("FAIL midrun_reset_state: busy=%0d done=%0d idx=%0d required 0 0 0",
               snap_busy, snap_done, snap_idx);
    end
    checks++;
    if (snap_x !== 0 || snap_y !== 0 || snap_z !== 0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %0d %0d %0d required 0 0 0", snap_x, snap_y, snap_z);
    end
    checks++;
    if (pc !== 0) begin
      errors++;
      $display("FAIL midrun_reset_no_done: pulses %0d required 0", pc);
    end
    run_op(1'b1, 6000, -2000, 100, -5, 1'b0, de, pc);
    model(1'b1, 6000, -2000, 100, ex, ey, ez);
    checks++;
    if (de !== 10 || int'(bus.x_out) !== ex || int'(bus.y_out) !== ey || int'(bus.z_out) !== ez) begin
      errors++;
      $display("FAIL after_reset_op: edge %0d got %0d %0d %0d required 10 %0d %0d %0d",
               de, bus.x_out, bus.y_out, bus.z_out, ex, ey, ez);
    end
  endtask

  task automatic test_random();
    int de, pc, ex, ey, ez, xi, yi, zi;
    bit m;
    for (int k = 0; k < 16; k++) begin
      m  = 1'($urandom);
      xi = wrap(int'($urandom));
      yi = wrap(int'($urandom));
      zi = wrap(int'($urandom));
      run_op(m, xi, yi, zi, -5, 1'b0, de, pc);
      model(m, xi, yi, zi, ex, ey, ez);
      checks++;
      if (de !== 10 || pc !== 1 || int'(bus.x_out) !== ex ||
          int'(bus.y_out) !== ey || int'(bus.z_out) !== ez) begin
        errors++;
        $display("FAIL random[%0d]: m=%0d in %0d %0d %0d edge %0d pulses %0d got %0d %0d %0d required %0d %0d %0d",
                 k, m, xi, yi, zi, de, pc, bus.x_out, bus.y_out, bus.z_out, ex, ey, ez);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dq[$];
    int ax, ay, az, bx, by, bz;
    model(1'b0, 5000, 1000, -3000, ax, ay, az);
    model(1'b1, 9000, -3000, 500, bx, by, bz);
    bus.mode  = 1'b0;
    bus.x_in  = 16'sd5000;
    bus.y_in  = 16'sd1000;
    bus.z_in  = -16'sd3000;
    bus.start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (bus.done) dq.push_back(n);
      if (n == 10) begin
        checks++;
        if (int'(bus.x_out) !== ax || int'(bus.y_out) !== ay || int'(bus.z_out) !== az) begin
          errors++;
          $display("FAIL b2b_first: got %0d %0d %0d required %0d %0d %0d",
                   bus.x_out, bus.y_out, bus.z_out, ax, ay, az);
        end
        bus.mode = 1'b1;
        bus.x_in = 16'sd9000;
        bus.y_in = -16'sd3000;
        bus.z_in = 16'sd500;
      end
      if (n == 21) begin
        checks++;
        if (int'(bus.x_out) !== bx || int'(bus.y_out) !== by || int'(bus.z_out) !== bz) begin
          errors++;
          $display("FAIL b2b_second: got %0d %0d %0d required %0d %0d %0d",
                   bus.x_out, bus.y_out, bus.z_out, bx, by, bz);
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (dq.size() !== 2 || dq[0] !== 10 || dq[1] !== 21) begin
      errors++;
      $display("FAIL b2b_done_edges: count %0d first %0d second %0d required 2 10 21",
               dq.size(), (dq.size() > 0) ? dq[0] : -1, (dq.size() > 1) ? dq[1] : -1);
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    real t, v;
    rom_tab[0] = '0;
    for (int i = 1; i < 16; i++) begin
      t          = 2.0 ** (-i);
      v          = 0.5 * $ln((1.0 + t) / (1.0 - t)) * 8192.0;
      rom_tab[i] = FW'($rtoi(v + 0.5));
    end
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    bus.z_in  = '0;

    test_reset();
    test_rotation(4096, 4269, "rot_pos");
    test_rotation(-4096, -4269, "rot_neg");
    test_vectoring();
    test_rom_trace();
    test_start_during_run();
    test_reset_midrun();
    test_random();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_hyperbolic_iter.md
CORDIC_HYPERBOLIC_ITER -- requirements
Module: cordic_hyperbolic_iter

Interface
REQ-001 SHALL have parameter FIXED_WIDTH, default 16, giving the signed data/angle width (Q2.13 at 16: 13 fraction bits).
REQ-002 SHALL have parameter ITERATIONS, default 9, giving the angle-ROM depth; shift indices used are 1..ITERATIONS-1.
REQ-003 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have start, input, 1, a request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have mode, input, 1: 0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); captured with start.
REQ-007 SHALL have x_in, y_in, z_in, input, FIXED_WIDTH each, signed operands captured with start.
REQ-008 SHALL have rom_idx, output, $clog2(ITERATIONS), the shift index requested from the external atanh ROM.
REQ-009 SHALL have rom_angle, input, FIXED_WIDTH, signed atanh(2^-rom_idx) returned combinationally in the same cycle.
REQ-010 SHALL have busy, output, 1, high while iterating.
REQ-011 SHALL have done, output, 1, a one-cycle pulse when results become valid.
REQ-012 SHALL have x_out, y_out, z_out, output, FIXED_WIDTH each, signed registered results.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after the last micro-iteration; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL execute the shift sequence 1,2,...,ITERATIONS-1, repeating index 4 and index 13 once each when present (default: 1,2,3,4,4,5,6,7,8; MICRO = 9 micro-iterations).
REQ-015 SHALL perform exactly one micro-iteration per RUN cycle, with rom_idx equal to the current shift index i during that cycle and 0 outside RUN.
REQ-016 SHALL choose direction d: rotation d=+1 if z>=0 else -1; vectoring d=+1 if y<0 else -1.
REQ-017 SHALL update simultaneously from pre-update values: x' = x + d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*rom_angle.
REQ-018 SHALL use arithmetic right shifts and FIXED_WIDTH two's-complement wrap-around, with no saturation and no rounding.
REQ-019 SHALL load working registers from x_in/y_in/z_in on the edge where start is sampled in IDLE.
REQ-020 SHALL assert done in the cycle following the MICRO-th RUN edge (done visible MICRO+1 edges after the start edge), for exactly one cycle.
REQ-021 SHALL drive busy high in RUN only and low in IDLE and DONE.
REQ-022 SHALL ignore start while in RUN or DONE, including any change to the captured operands.
REQ-023 SHALL update x_out/y_out/z_out only on entry to DONE and hold them until the next completed operation.
REQ-024 SHALL NOT compensate the hyperbolic gain (~0.8282 for the default sequence); the caller pre-scales.
REQ-025 SHALL accept start in the same cycle that returns to IDLE only after DONE has ended; back-to-back operations therefore have a 1-cycle IDLE gap minimum.

Reset
REQ-026 SHALL, on rst high at a clock edge, enter IDLE with busy=0, done=0, rom_idx=0, and all outputs/working registers 0, aborting any operation in progress.
REQ-027 SHALL give rst priority over start in the same cycle.

Verification
REQ-028 SHALL cover rotation: mode=0, x_in=9892 (1/K), y_in=0, z_in=4096 (0.5) -> x_out ~9237 (cosh 0.5), y_out ~4269 (sinh 0.5), z_out ~0, each within +/-24 LSB; done after 10 edges.
REQ-029 SHALL cover vectoring: mode=1, x_in=8192, y_in=4096, z_in=0 -> z_out ~4500 (atanh 0.5) within +/-16 LSB, y_out within +/-16 LSB of 0.
REQ-030 SHALL cover the rom_idx trace during RUN, which equals 1,2,3,4,4,5,6,7,8 on consecutive cycles, then 0.
REQ-031 SHALL cover start pulsed at cycle 3 of RUN with different operands -> no effect on results or timing, single done pulse.
REQ-032 SHALL cover rst asserted at RUN cycle 5 -> next cycle IDLE, busy=0, done=0, outputs 0, no done pulse; a subsequent start completes normally.
REQ-033 SHALL cover negative z_in=-4096 in rotation -> y_out ~-4269 +/-24, x_out ~9237 +/-24.
